// File: rtl/bc_horner_ctrl.sv
// bc_horner_ctrl: Horner-rule sequencer for the polynomial datapath.
// Evaluates Pronto = A*x^2 + B*x + C as H=A, H=H*x+B, H=H*x+C, S=H.
//
// Parameter:
//   MULT_LAT  extra settle cycles per H step before LH pulses (0..15)
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request one evaluation (sampled in IDLE only)
//   busy, done      handshake: busy CLR..DONE, done one-cycle pulse
//   M0              coefficient select  (0=A 1=B 2=C)
//   M1              multiplier operand  (0=x 1=const 1)
//   M2              H input select      (0=mult-add 1=coef 2=zero)
//   LX, RSTX        load / clear R0 (x)
//   LH, RSTH        load / clear H
//   LS              load result register S
// Build option:
//   BC_CHAIN_EN     when defined, start seen in DONE goes straight to CLR
module bc_horner_ctrl #(
  parameter int MULT_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       RSTX,
  output logic       LH,
  output logic       RSTH,
  output logic       LS
);

  localparam int CW = (MULT_LAT < 1) ? 1 : $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LDX   = 3'd2;
  localparam logic [2:0] S_HA    = 3'd3;
  localparam logic [2:0] S_HB    = 3'd4;
  localparam logic [2:0] S_HC    = 3'd5;
  localparam logic [2:0] S_STORE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // Counter defaults to zero so it is already cleared when an H step
  // is entered; it only advances while waiting inside an H step.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        state_d = S_LDX;
      end
      S_LDX: begin
        state_d = S_HA;
      end
      S_HA: begin
        if (cnt_last) state_d = S_HB;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_HB: begin
        if (cnt_last) state_d = S_HC;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_HC: begin
        if (cnt_last) state_d = S_STORE;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_STORE: begin
        state_d = S_DONE;
      end
      S_DONE: begin
`ifdef BC_CHAIN_EN
        state_d = start ? S_CLR : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode; selects stay fixed for the whole H step and only
  // LH depends on the wait counter.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    M0   = 2'd0;
    M1   = 2'd0;
    M2   = 2'd0;
    LX   = 1'b0;
    RSTX = 1'b0;
    LH   = 1'b0;
    RSTH = 1'b0;
    LS   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_CLR: begin
        busy = 1'b1;
        RSTX = 1'b1;
        RSTH = 1'b1;
      end
      S_LDX: begin
        busy = 1'b1;
        LX   = 1'b1;
      end
      S_HA: begin
        busy = 1'b1;
        M0   = 2'd0;
        M1   = 2'd1;
        M2   = 2'd1;
        LH   = cnt_last;
      end
      S_HB: begin
        busy = 1'b1;
        M0   = 2'd1;
        LH   = cnt_last;
      end
      S_HC: begin
        busy = 1'b1;
        M0   = 2'd2;
        LH   = cnt_last;
      end
      S_STORE: begin
        busy = 1'b1;
        LS   = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bc_horner_ctrl.sv
// tb_bc_horner_ctrl: scoreboard bench for bc_horner_ctrl.
// Two instances (MULT_LAT=0 and 2) share stimulus; each drives a datapath model.
module tb_bc_horner_ctrl;

  logic clk;
  logic rst_n;
  logic start;

  logic       busy0, done0, lx0, rstx0, lh0, rsth0, ls0;
  logic [1:0] m00, m10, m20;
  logic       busy2, done2, lx2, rstx2, lh2, rsth2, ls2;
  logic [1:0] m02, m12, m22;

  bc_horner_ctrl #(.MULT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy0), .done(done0),
    .M0(m00), .M1(m10), .M2(m20),
    .LX(lx0), .RSTX(rstx0), .LH(lh0), .RSTH(rsth0), .LS(ls0)
  );

  bc_horner_ctrl #(.MULT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy2), .done(done2),
    .M0(m02), .M1(m12), .M2(m22),
    .LX(lx2), .RSTX(rstx2), .LH(lh2), .RSTH(rsth2), .LS(ls2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [12:0] v0, v2;
  assign v0 = {busy0, done0, m00, m10, m20, lx0, rstx0, lh0, rsth0, ls0};
  assign v2 = {busy2, done2, m02, m12, m22, lx2, rstx2, lh2, rsth2, ls2};

  // Expected output vector n cycles after start was accepted (n=1 is CLR).
  function automatic logic [12:0] exp_vec(input int l, input int n);
    logic b, d, lx, rx, lh, rh, ls;
    logic [1:0] m0, m1, m2;
    int h, c;
    b = 0; d = 0; lx = 0; rx = 0; lh = 0; rh = 0; ls = 0;
    m0 = 0; m1 = 0; m2 = 0;
    if (n >= 1 && n <= 7 + 3 * l) begin
      b = 1;
      if (n == 1) begin
        rx = 1;
        rh = 1;
      end else if (n == 2) begin
        lx = 1;
      end else if (n == 6 + 3 * l) begin
        ls = 1;
      end else if (n == 7 + 3 * l) begin
        d = 1;
      end else begin
        h  = (n - 3) / (l + 1);
        c  = (n - 3) % (l + 1);
        m0 = h[1:0];
        if (h == 0) begin
          m1 = 2'd1;
          m2 = 2'd1;
        end
        lh = (c == l);
      end
    end
    return {b, d, m0, m1, m2, lx, rx, lh, rh, ls};
  endfunction

  logic [31:0] ca, cb, cc, cx;

  function automatic logic [31:0] poly(input logic [31:0] a, b, c, x);
    return a * x * x + b * x + c;
  endfunction

  function automatic logic [31:0] h_in(input logic [1:0] m0, m1, m2,
                                       input logic [31:0] h, r0);
    logic [31:0] coef, op;
    coef = (m0 == 2'd0) ? ca : (m0 == 2'd1) ? cb : cc;
    op   = (m1 == 2'd1) ? 32'd1 : r0;
    if (m2 == 2'd0)      return h * op + coef;
    else if (m2 == 2'd1) return coef;
    else                 return 32'd0;
  endfunction

  logic [31:0] r0_0, h_0, s_0;
  logic [31:0] r0_2, h_2, s_2;

  always @(posedge clk) begin
    if (rstx0)    r0_0 <= 32'd0;
    else if (lx0) r0_0 <= cx;
    if (rsth0)    h_0 <= 32'd0;
    else if (lh0) h_0 <= h_in(m00, m10, m20, h_0, r0_0);
    if (ls0)      s_0 <= h_0;
  end

  always @(posedge clk) begin
    if (rstx2)    r0_2 <= 32'd0;
    else if (lx2) r0_2 <= cx;
    if (rsth2)    h_2 <= 32'd0;
    else if (lh2) h_2 <= h_in(m02, m12, m22, h_2, r0_2);
    if (ls2)      s_2 <= h_2;
  end

  logic [31:0] q0[$];
  logic [31:0] q2[$];
  logic        free_run = 1'b0;
  logic [31:0] poly_cur;

  always @(negedge clk) begin
    if (done0) begin
      if (free_run) check("pronto0_chain", s_0, poly_cur);
      else if (q0.size() == 0) check("sb0_empty", 32'(q0.size()), 32'd1);
      else check("pronto0", s_0, q0.pop_front());
    end
    if (done2) begin
      if (free_run) check("pronto2_chain", s_2, poly_cur);
      else if (q2.size() == 0) check("sb2_empty", 32'(q2.size()), 32'd1);
      else check("pronto2", s_2, q2.pop_front());
    end
  end

  // One accepted run; start re-driven during [hold_lo,hold_hi],
  // reset pulsed during cycle rst_at (0 = none).
  task automatic run(input string tag, input int hold_lo,
                     input int hold_hi, input int rst_at,
                     input logic [31:0] exp_p);
    logic [12:0] e0, e2;
    q0.push_back(exp_p);
    q2.push_back(exp_p);
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (rst_at > 0 && n > rst_at) begin
        e0 = '0;
        e2 = '0;
      end else begin
        e0 = exp_vec(0, n);
        e2 = exp_vec(2, n);
      end
      check($sformatf("%s_L0_n%0d", tag, n), 32'(v0), 32'(e0));
      check($sformatf("%s_L2_n%0d", tag, n), 32'(v2), 32'(e2));
      start = (n >= hold_lo && n <= hold_hi);
      rst_n = (n != rst_at);
    end
    rst_n = 1'b1;
    start = 1'b0;
    if (rst_at > 0) begin
      q0.delete();
      q2.delete();
    end
    check($sformatf("%s_sb0_left", tag), 32'(q0.size()), 32'd0);
    check($sformatf("%s_sb2_left", tag), 32'(q2.size()), 32'd0);
  endtask

  initial begin
    int d0[$];
    int d2[$];
    int idle0, idle2, p0, p2, ei0, ei2;
    bit ok;

    rst_n = 1'b0;
    start = 1'b1;
    ca = 0; cb = 0; cc = 0; cx = 0;
    poly_cur = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_L0", 32'(v0), 32'd0);
      check("rst_L2", 32'(v2), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_L0_%0d", i), 32'(v0), 32'd0);
      check($sformatf("idle_L2_%0d", i), 32'(v2), 32'd0);
    end

    ca = 2; cb = 3; cc = 4; cx = 5;
    run("basic", 0, 0, 0, 32'd69);

    for (int i = 0; i < 3; i++) begin
      ca = $urandom_range(0, 255);
      cb = $urandom_range(0, 255);
      cc = $urandom_range(0, 255);
      cx = $urandom_range(0, 255);
      run($sformatf("rnd%0d", i), 0, 0, 0, poly(ca, cb, cc, cx));
    end

    ca = 7; cb = 1; cc = 9; cx = 3;
    run("busy_start", 3, 5, 0, poly(ca, cb, cc, cx));

    run("rst_n4", 0, 0, 4, poly(ca, cb, cc, cx));
    run("rst_n7", 0, 0, 7, poly(ca, cb, cc, cx));

    ca = 1; cb = 2; cc = 3; cx = 4;
    poly_cur = poly(ca, cb, cc, cx);
    free_run = 1'b1;
    idle0 = 0;
    idle2 = 0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done0) d0.push_back(c);
      if (done2) d2.push_back(c);
      if (!busy0) idle0++;
      if (!busy2) idle2++;
    end
    start = 1'b0;
`ifdef BC_CHAIN_EN
    p0 = 7;  p2 = 13; ei0 = 0; ei2 = 0;
`else
    p0 = 8;  p2 = 14; ei0 = 5; ei2 = 2;
`endif
    check("chain_first0", 32'(d0.size() >= 1 ? d0[0] : -1), 32'd7);
    check("chain_first2", 32'(d2.size() >= 1 ? d2[0] : -1), 32'd13);
    check("chain_per0", 32'(d0.size() >= 2 ? d0[1] - d0[0] : -1), 32'(p0));
    check("chain_per2", 32'(d2.size() >= 2 ? d2[1] - d2[0] : -1), 32'(p2));
    check("chain_idle0", 32'(idle0), 32'(ei0));
    check("chain_idle2", 32'(idle2), 32'(ei2));

    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (!busy0 && !busy2) ok = 1'b1;
    end
    check("drain_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    free_run = 1'b0;
    check("final_L0", 32'(v0), 32'd0);
    check("final_L2", 32'(v2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
